// File: rtl/cbud_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module : cbud_share_ctrl_pkg
//  Brief  : Shared types and helpers for the shared cascaded up/down counter
//           controller: FSM state encoding and round-robin index wrapping.
//  Rev    : 1.0  initial release
// ============================================================================
package cbud_share_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_GRANT = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_TERM  = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  // Wraps an index that may exceed the requester count by less than n.
  function automatic int rr_wrap(input int a, input int n);
    return (a >= n) ? (a - n) : a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cbud_share_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module : cbud_share_ctrl_if
//  Brief  : Requester command/grant bus plus counter-chain control bus.
//  Ports  : req/cmd_val/cmd_dn/cmd_per  requester commands
//           gnt/done/busy               status back to requesters
//           cnt_clr/cnt_ld/cnt_en/cnt_dnup/cnt_d  chain control
//           cnt_cao                     chain terminal carry
//  Rev    : 1.0  initial release
// ============================================================================
interface cbud_share_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] cmd_val;
  logic [NREQ-1:0]       cmd_dn;
  logic [NREQ-1:0]       cmd_per;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  cnt_clr;
  logic                  cnt_ld;
  logic                  cnt_en;
  logic                  cnt_dnup;
  logic [WIDTH-1:0]      cnt_d;
  logic                  cnt_cao;

  // Requester and chain side.
  modport master (
    output req, cmd_val, cmd_dn, cmd_per, cnt_cao,
    input  gnt, done, busy, cnt_clr, cnt_ld, cnt_en, cnt_dnup, cnt_d
  );

  // Controller side.
  modport slave (
    input  req, cmd_val, cmd_dn, cmd_per, cnt_cao,
    output gnt, done, busy, cnt_clr, cnt_ld, cnt_en, cnt_dnup, cnt_d
  );
endinterface
`default_nettype wire

// File: rtl/cbud_share_ctrl_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module : cbud_rr_arb
//  Brief  : Combinational NREQ-way round-robin pick. The winner is the first
//           set request at or after ptr, wrapping. The pointer register is
//           owned by the parent.
//  Ports  : req  request vector
//           ptr  highest-priority index
//           any  at least one request set
//           idx  winning index (0 when any = 0)
//  Rev    : 1.0  initial release
// ============================================================================
module cbud_rr_arb
  import cbud_share_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            any,
  output logic [PW-1:0]   idx
);

  always_comb begin
    int j;
    any = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = rr_wrap(int'(ptr) + k, NREQ);
      if (!any && req[j]) begin
        any = 1'b1;
        idx = PW'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cbud_share_ctrl.sv
`default_nettype none
// ============================================================================
//  Module : cbud_share_ctrl
//  Brief  : Shares one WIDTH-bit cascaded up/down counter chain among NREQ
//           requesters. Round-robin arbitration, command latching, and
//           load / run / terminal-count sequencing with periodic auto-reload.
//  Ports  : clk  clock, all state on rising edge
//           cs   synchronous active-high reset; also forces cnt_clr
//           bus  controller side of cbud_share_ctrl_if
//  Rev    : 1.0  initial release
// ============================================================================
module cbud_share_ctrl
  import cbud_share_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREQ  = 2
) (
  input  logic                clk,
  input  logic                cs,
  cbud_share_ctrl_if.slave    bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state;
  state_t            state_nx;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     owner;
  logic [PW-1:0]     ptr_after;
  logic [PW-1:0]     win_idx;
  logic              win_any;
  logic [WIDTH-1:0]  val_q;
  logic              dn_q;
  logic              per_q;
  logic [NREQ-1:0]   owner_oh;
  logic              owner_req;
  logic              others_req;
  logic [WIDTH-1:0]  sel_val;
  logic              sel_dn;
  logic              sel_per;

  cbud_rr_arb #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req  (bus.req),
    .ptr  (ptr),
    .any  (win_any),
    .idx  (win_idx)
  );

  // Owner decode and command select for the current owner.
  always_comb begin
    owner_oh = '0;
    sel_val  = '0;
    sel_dn   = 1'b0;
    sel_per  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == PW'(i)) begin
        owner_oh[i] = 1'b1;
        sel_val     = bus.cmd_val[i*WIDTH +: WIDTH];
        sel_dn      = bus.cmd_dn[i];
        sel_per     = bus.cmd_per[i];
      end
    end
    owner_req  = |(bus.req & owner_oh);
    others_req = |(bus.req & ~owner_oh);
    ptr_after  = PW'(rr_wrap(int'(owner) + 1, NREQ));
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (win_any) state_nx = ST_GRANT;
      ST_GRANT: state_nx = owner_req ? ST_LOAD : ST_IDLE;
      ST_LOAD:  state_nx = owner_req ? ST_RUN : ST_ABORT;
      // Release beats a same-cycle terminal carry.
      ST_RUN: begin
        if (!owner_req)       state_nx = ST_ABORT;
        else if (bus.cnt_cao) state_nx = ST_TERM;
      end
      // Periodic reload only while nobody else is waiting.
      ST_TERM:  state_nx = (per_q && owner_req && !others_req) ? ST_LOAD : ST_IDLE;
      ST_ABORT: state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (cs) begin
      state <= ST_IDLE;
      ptr   <= '0;
      owner <= '0;
      val_q <= '0;
      dn_q  <= 1'b0;
      per_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && win_any) begin
        owner <= win_idx;
      end
      // Command is captured once per grant; reloads reuse it.
      if (state == ST_GRANT) begin
        val_q <= sel_val;
        dn_q  <= sel_dn;
        per_q <= sel_per;
      end
      if ((state == ST_TERM && state_nx == ST_IDLE) || state == ST_ABORT) begin
        ptr <= ptr_after;
      end
    end
  end

  // Moore outputs; cs overrides so the chain clears on the reset edge.
  always_comb begin
    bus.gnt      = '0;
    bus.done     = '0;
    bus.busy     = 1'b0;
    bus.cnt_clr  = 1'b0;
    bus.cnt_ld   = 1'b0;
    bus.cnt_en   = 1'b0;
    bus.cnt_dnup = 1'b0;
    bus.cnt_d    = '0;
    if (cs) begin
      bus.cnt_clr = 1'b1;
    end else begin
      bus.gnt      = (state != ST_IDLE) ? owner_oh : '0;
      bus.done     = (state == ST_TERM) ? owner_oh : '0;
      bus.busy     = (state != ST_IDLE);
      bus.cnt_clr  = (state == ST_ABORT);
      bus.cnt_ld   = (state == ST_LOAD);
      bus.cnt_en   = (state == ST_RUN);
      bus.cnt_dnup = dn_q;
      bus.cnt_d    = val_q;
    end
  end

endmodule
`default_nettype wire
